wb_uart_bridge: RTL and testbench
=================================

# wb_uart_bridge

UART-to-Wishbone debug initiator. It receives binary command frames on a debug UART and runs single Wishbone read or write cycles on the peripheral bus, acting as the bus master in front of peripherals such as the `misc` register block. It then returns a status byte and any read data over the UART. The block sits in the `clk_sys` domain, beside the SoC's own bus master, and gives bench and bring-up access to peripheral registers without firmware.

## Interface
Parameters:
- `DIV`, 266: clocks per UART bit (30.72 MHz / 115200); minimum 4.
- `WB_TO`, 255: maximum clocks `wb_cyc` stays high waiting for `wb_ack`.
- `IBT`, 20*`DIV`: inter-byte timeout inside a frame, in clocks.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `uart_rx` in 1: serial in, 8N1, idle high, asynchronous to `clk`.
- `uart_tx` out 1: serial out, 8N1, idle high.
- `wb_addr` out 16: bus address.
- `wb_wdata` out 32: write data.
- `wb_wmsk` out 4: byte write mask.
- `wb_we` out 1: write enable.
- `wb_cyc` out 1: cycle request.
- `wb_rdata` in 32: read data, valid when `wb_ack`=1.
- `wb_ack` in 1: single-cycle acknowledge.

## Operation
- RX path:
  - `uart_rx` passes through a 2-FF synchronizer.
  - A start bit is detected on a falling edge while idle, then confirmed low at DIV/2.
  - Data bits are sampled every `DIV` clocks after that, LSB first, then the stop bit.
  - Stop bit = 0 is a framing error: discard the byte and return the parser to IDLE.
  - Otherwise emit a one-clock `rx_valid` pulse with the byte, at the stop-bit sample.
- Frame formats (bytes, multi-byte fields MSB first):
  - Write: `0x1m`, A1, A0, D3, D2, D1, D0, where m = `wb_wmsk`. A write with m=0 is still run on the bus.
  - Read: `0x20`, A1, A0.
  - Any other first byte is ignored silently and the parser stays in IDLE (resync).
- Parser FSM states:
  - IDLE: on a recognized command go to ADDR.
  - ADDR: take 2 bytes, then go to DATA (write) or BUS (read).
  - DATA: take 4 bytes, then go to BUS.
  - BUS: run the bus cycle, then go to RESP.
  - RESP: send the response, then return to IDLE.
  - A byte counter sequences ADDR/DATA.
  - If no byte arrives for `IBT` clocks while in ADDR/DATA, abort to IDLE with no response and no bus cycle.
- Bus cycle (BUS):
  - `wb_addr`, `wb_wdata`, `wb_wmsk` and `wb_we` are set up and stay stable for the whole cycle.
  - `wb_cyc`=1 until `wb_ack`=1 or `WB_TO` clocks have elapsed.
  - On ack: capture `wb_rdata` and set status 0xA5.
  - On timeout: set status 0xEE; read data is not sent.
- Response (RESP):
  - Write, ok or timeout: status byte only.
  - Read ok: 0xA5, then D3, D2, D1, D0.
  - Read timeout: 0xEE only.
- Half-duplex: bytes that complete during BUS or RESP are discarded. The RX deserializer keeps running so it stays bit-aligned.
- `wb_addr`, `wb_wdata` and `wb_wmsk` hold their last values while idle. `wb_we` returns to 0 when `wb_cyc` drops.

## Timing
- Reset values: `uart_tx`=1, `wb_cyc`=0, `wb_we`=0, `wb_addr`=0, `wb_wdata`=0, `wb_wmsk`=0. FSM in IDLE, counters cleared.
- Reset mid-frame or mid-cycle: all outputs return immediately (asynchronously) to their reset values. Any partial TX byte is truncated with the line held high.
- `wb_cyc` rises on the clock after the `rx_valid` of the last frame byte.
- Ack handling:
  - `wb_ack` seen in cycle N: `wb_cyc`=0 in cycle N+1; `wb_rdata` is sampled in cycle N.
  - `wb_ack` in the first `wb_cyc` cycle is legal.
  - `wb_ack` while `wb_cyc`=0 is ignored.
- Timeout: `wb_cyc` is high for exactly `WB_TO` clocks, then falls. An ack arriving in the same cycle as expiry counts as an ack.
- TX:
  - The start bit of the first response byte begins on the clock after `wb_cyc` falls.
  - Each byte is exactly 10*`DIV` clocks.
  - Response bytes are sent back-to-back with no idle gap.
  - Return to IDLE on the clock after the last stop bit ends.
- Bit-time tolerance: RX accepts ±4 % baud mismatch.

## Test plan
- DIV=8. Send 0x1F,0x00,0x04,0xDE,0xAD,0xBE,0xEF; responder acks after 3 clocks → one cycle with addr=0x0004, wdata=0xDEADBEEF, wmsk=0xF, we=1, `wb_cyc` high for 4 clocks; TX returns 0xA5.
- Send 0x20,0x12,0x34; ack in the first cycle with rdata=0x01020304 → `wb_cyc` high for 1 clock, we=0; TX returns 0xA5,0x01,0x02,0x03,0x04 back-to-back over 50*DIV clocks.
- WB_TO=16, responder never acks, send a read → `wb_cyc` high for exactly 16 clocks; TX returns 0xEE only.
- Send garbage 0x55, then a byte with stop bit=0, then a valid read → no bus activity before the read; the read completes normally.
- Send 0x1F,0x00, then idle for more than `IBT` → no `wb_cyc`, no TX. A following valid write executes correctly.
- Assert `rst_n`=0 while `wb_cyc`=1 and TX is mid-byte → `wb_cyc`=0 and `uart_tx`=1 immediately; after release the next frame works.

Source files
------------

// File: rtl/wb_uart_bridge.sv
// wb_uart_bridge: debug UART command frames in, single Wishbone read/write cycles out,
// status byte and optional read data returned on the UART.
module wb_uart_bridge #(
  parameter int DIV   = 266,
  parameter int WB_TO = 255,
  parameter int IBT   = 20 * DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [15:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_wmsk,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack
);
  localparam int DW = $clog2(DIV + 1);
  localparam int TW = $clog2(WB_TO + 1);
  localparam int IW = $clog2(IBT + 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
  state_t st, st_n;
  logic [2:0] rx_ff;
  logic rx_s, rx_act, rx_tick, rx_valid, rx_ferr;
  logic [DW-1:0] rx_cnt;
  logic [3:0] rx_bit;
  logic [7:0] rx_sh;
  logic is_wr, cmd_ok, in_frame, ibt_exp, abort, last_byte, bus_ack, bus_to, bus_done;
  logic [3:0] mk;
  logic [2:0] bcnt, bi, resp_last;
  logic [IW-1:0] ibt;
  logic [TW-1:0] to_cnt;
  logic [39:0] fr, resp;
  logic tx_act, tx_last, tx_done;
  logic [DW-1:0] tx_cnt;
  logic [3:0] tx_bit;
  logic [8:0] tx_sh;
  // rx_ff[1] is the synchronized line, rx_ff[2] its previous value for edge detection
  assign rx_s     = rx_ff[1];
  assign rx_tick  = rx_act && rx_cnt == '0;
  assign rx_valid = rx_tick && rx_bit == 4'd9 && rx_s;
  assign rx_ferr  = rx_tick && rx_bit == 4'd9 && !rx_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff  <= 3'b111;
      rx_act <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_ff <= {rx_ff[1:0], uart_rx};
      if (!rx_act) begin
        if (rx_ff[2] && !rx_s) begin
          rx_act <= 1'b1;
          rx_cnt <= DW'(DIV / 2 - 1);
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= DW'(DIV - 1);
        rx_bit <= rx_bit + 4'd1;
        if ((rx_bit == 4'd0 && rx_s) || rx_bit == 4'd9) rx_act <= 1'b0;
        if (rx_bit != 4'd0 && rx_bit != 4'd9) rx_sh <= {rx_s, rx_sh[7:1]};
      end
    end
  end
  assign cmd_ok    = rx_sh[7:4] == 4'h1 || rx_sh == 8'h20;
  assign in_frame  = st == ADDR || st == DATA;
  assign ibt_exp   = in_frame && !rx_valid && ibt == IW'(IBT - 1);
  assign abort     = in_frame && (ibt_exp || rx_ferr);
  assign last_byte = rx_valid && ((st == ADDR && bcnt == 3'd1 && !is_wr) || (st == DATA && bcnt == 3'd5));
  assign bus_ack   = st == BUS && wb_cyc && wb_ack;
  assign bus_to    = st == BUS && wb_cyc && !wb_ack && to_cnt == TW'(WB_TO - 1);
  assign bus_done  = bus_ack || bus_to;
  assign tx_last   = tx_act && tx_cnt == '0 && tx_bit == 4'd9;
  assign tx_done   = tx_last && bi == resp_last;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = (rx_valid && cmd_ok) ? ADDR : IDLE;
      ADDR:    st_n = abort ? IDLE : (rx_valid && bcnt == 3'd1) ? (is_wr ? DATA : BUS) : ADDR;
      DATA:    st_n = abort ? IDLE : last_byte ? BUS : DATA;
      BUS:     st_n = bus_done ? RESP : BUS;
      RESP:    st_n = tx_done ? IDLE : RESP;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  end
  // fr collects address/data bytes; bus outputs only change when a cycle is launched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr     <= 1'b0;
      mk        <= '0;
      bcnt      <= '0;
      ibt       <= '0;
      fr        <= '0;
      to_cnt    <= '0;
      wb_cyc    <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_wdata  <= '0;
      wb_wmsk   <= '0;
      resp      <= '0;
      resp_last <= '0;
    end else begin
      if (st == IDLE && rx_valid && cmd_ok) begin
        is_wr <= rx_sh[7:4] == 4'h1;
        mk    <= rx_sh[3:0];
        bcnt  <= '0;
        ibt   <= '0;
      end
      if (in_frame) begin
        ibt <= rx_valid ? '0 : ibt + 1'b1;
        if (rx_valid) begin
          fr   <= {fr[31:0], rx_sh};
          bcnt <= bcnt + 3'd1;
        end
      end
      if (last_byte) begin
        wb_cyc  <= 1'b1;
        wb_we   <= is_wr;
        to_cnt  <= '0;
        wb_addr <= is_wr ? fr[39:24] : {fr[7:0], rx_sh};
        if (is_wr) begin
          wb_wdata <= {fr[23:0], rx_sh};
          wb_wmsk  <= mk;
        end
      end
      if (st == BUS) begin
        to_cnt <= to_cnt + 1'b1;
        if (bus_done) begin
          wb_cyc    <= 1'b0;
          wb_we     <= 1'b0;
          resp      <= {bus_ack ? 8'hA5 : 8'hEE, bus_ack ? wb_rdata : 32'h0};
          resp_last <= (bus_ack && !is_wr) ? 3'd4 : 3'd0;
        end
      end
      if (tx_last && !tx_done) resp <= {resp[31:0], 8'h00};
    end
  end
  // next response byte is loaded straight into the start bit so bytes run back-to-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx <= 1'b1;
      tx_act  <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      bi      <= '0;
    end else if (st != RESP) begin
      uart_tx <= 1'b1;
      tx_act  <= 1'b0;
      bi      <= '0;
    end else if (!tx_act) begin
      tx_act  <= 1'b1;
      uart_tx <= 1'b0;
      tx_sh   <= {1'b1, resp[39:32]};
      tx_cnt  <= DW'(DIV - 1);
      tx_bit  <= '0;
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else if (tx_bit == 4'd9) begin
      if (tx_done) begin
        tx_act <= 1'b0;
      end else begin
        bi      <= bi + 3'd1;
        uart_tx <= 1'b0;
        tx_sh   <= {1'b1, resp[31:24]};
        tx_bit  <= '0;
        tx_cnt  <= DW'(DIV - 1);
      end
    end else begin
      uart_tx <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[8:1]};
      tx_bit  <= tx_bit + 4'd1;
      tx_cnt  <= DW'(DIV - 1);
    end
  end
endmodule

// File: tb/tb_wb_uart_bridge.sv
// tb_wb_uart_bridge: directed and randomized frames against a transaction-level model of the bridge.
module tb_wb_uart_bridge;
  localparam int DIV = 8, WB_TO = 16, IBT = 20 * DIV;
  logic clk = 0, rst_n = 0, uart_rx = 1, uart_tx, wb_we, wb_cyc, wb_ack = 0;
  logic [15:0] wb_addr;
  logic [31:0] wb_wdata, wb_rdata = 0;
  logic [3:0] wb_wmsk;
  wb_uart_bridge #(.DIV(DIV), .WB_TO(WB_TO), .IBT(IBT)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_rdata(wb_rdata), .wb_ack(wb_ack)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc_no = 0;
  always @(posedge clk) cyc_no++;
  // responder: ack in the ack_at-th cycle of wb_cyc (0 = never), junk rdata otherwise
  int ack_at = 0, rk = 0;
  logic [31:0] rsp_data = 0;
  bit stray_ack = 0;
  always @(negedge clk) begin
    if (wb_cyc) begin
      rk++;
      wb_ack = (rk == ack_at);
      wb_rdata = (rk == ack_at) ? rsp_data : $urandom;
    end else begin
      rk = 0;
      wb_ack = stray_ack;
      wb_rdata = $urandom;
    end
  end
  typedef struct {logic [15:0] a; logic [31:0] d; logic [3:0] m; logic we; int len; int fall;} bus_t;
  bus_t busq[$];
  bus_t cur;
  int unstable = 0, we_bad = 0;
  logic cyc_d = 0;
  always @(negedge clk) begin
    if (wb_cyc === 1'b1 && !cyc_d) begin
      cur.a = wb_addr; cur.d = wb_wdata; cur.m = wb_wmsk; cur.we = wb_we; cur.len = 1;
    end else if (wb_cyc === 1'b1) begin
      cur.len++;
      if ({wb_addr, wb_wdata, wb_wmsk, wb_we} !== {cur.a, cur.d, cur.m, cur.we}) unstable++;
    end else if (cyc_d) begin
      cur.fall = cyc_no;
      busq.push_back(cur);
    end
    if (wb_cyc !== 1'b1 && wb_we === 1'b1) we_bad++;
    cyc_d = (wb_cyc === 1'b1);
  end
  logic [7:0] txq[$];
  int txs[$];
  initial forever begin : txdec
    int s;
    logic [7:0] b;
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      s = cyc_no;
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      txq.push_back(b);
      txs.push_back(s);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask
  logic [31:0] last_d = 0;
  logic [3:0] last_m = 0;
  task automatic run(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic [31:0] rd, input int ackat, input bit stray, input string tag);
    logic [7:0] f[7];
    logic [7:0] exp_b[$];
    int n, len;
    bit ok;
    f[0] = wr ? {4'h1, m} : 8'h20;
    f[1] = a[15:8]; f[2] = a[7:0];
    f[3] = d[31:24]; f[4] = d[23:16]; f[5] = d[15:8]; f[6] = d[7:0];
    n = wr ? 7 : 3;
    ok = ackat >= 1 && ackat <= WB_TO;
    len = ok ? ackat : WB_TO;
    exp_b.push_back(ok ? 8'hA5 : 8'hEE);
    if (!wr && ok) for (int i = 3; i >= 0; i--) exp_b.push_back(rd[8*i +: 8]);
    ack_at = ackat; rsp_data = rd; stray_ack = stray;
    busq.delete(); txq.delete(); txs.delete(); unstable = 0; we_bad = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(f[i], 1'b1);
      repeat ($urandom_range(0, 3 * DIV)) @(negedge clk);
    end
    for (int t = 0; t < 5000 && !(busq.size() >= 1 && txq.size() >= exp_b.size()); t++) @(negedge clk);
    repeat (12 * DIV) @(negedge clk);
    stray_ack = 0;
    chk({tag, "_ncyc"}, busq.size(), 1);
    if (busq.size() >= 1) begin
      chk({tag, "_addr"}, busq[0].a, a);
      chk({tag, "_wdata"}, busq[0].d, wr ? d : last_d);
      chk({tag, "_wmsk"}, busq[0].m, wr ? m : last_m);
      chk({tag, "_we"}, busq[0].we, wr);
      chk({tag, "_len"}, busq[0].len, len);
      chk({tag, "_txstart"}, txs.size() > 0 ? txs[0] : 0, busq[0].fall + 1);
    end
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_we_idle"}, we_bad, 0);
    chk({tag, "_ntx"}, txq.size(), exp_b.size());
    for (int i = 0; i < txq.size() && i < exp_b.size(); i++) begin
      chk($sformatf("%s_tx%0d", tag, i), txq[i], exp_b[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), txs[i] - txs[i-1], 10 * DIV);
    end
    if (wr) begin last_d = d; last_m = m; end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", uart_tx, 1);
    chk("reset_cyc", wb_cyc, 0);
    chk("reset_we", wb_we, 0);
    chk("reset_addr", wb_addr, 0);
    chk("reset_wdata", wb_wdata, 0);
    chk("reset_wmsk", wb_wmsk, 0);
    rst_n = 1;
    repeat (4 * DIV) @(negedge clk);
    run(1, 16'h0004, 32'hDEADBEEF, 4'hF, 32'h0, 4, 0, "write_ack3");
    run(0, 16'h1234, 32'h0, 4'h0, 32'h01020304, 1, 0, "read_ack1");
    run(0, 16'($urandom), 32'h0, 4'h0, $urandom, 0, 1, "read_timeout");
    run(1, 16'($urandom), $urandom, 4'($urandom), 32'h0, 0, 0, "write_timeout");
    run(0, 16'($urandom), 32'h0, 4'h0, $urandom, WB_TO, 0, "read_ack_at_expiry");
    run(1, 16'($urandom), $urandom, 4'h0, 32'h0, 2, 1, "write_mask0");
    busq.delete(); txq.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'h20, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    chk("garbage_nocyc", busq.size(), 0);
    chk("garbage_notx", txq.size(), 0);
    run(0, 16'h00F0, 32'h0, 4'h0, $urandom, 3, 0, "read_after_garbage");
    busq.delete(); txq.delete();
    send_byte(8'h1F, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (IBT + 10 * DIV) @(negedge clk);
    chk("ibt_nocyc", busq.size(), 0);
    chk("ibt_notx", txq.size(), 0);
    run(1, 16'hBEEF, $urandom, 4'h5, 32'h0, 2, 0, "write_after_ibt");
    ack_at = 0;
    send_byte(8'h20, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    for (int t = 0; t < 300 && wb_cyc !== 1'b1; t++) @(negedge clk);
    chk("rst_cyc_pre", wb_cyc, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_tx_idle", uart_tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1; last_d = 0; last_m = 0;
    repeat (4 * DIV) @(negedge clk);
    ack_at = 1; rsp_data = 32'h11223344;
    send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    for (int t = 0; t < 500 && uart_tx !== 1'b0; t++) @(negedge clk);
    repeat (2 * DIV + 2) @(negedge clk);
    chk("rst_tx_pre", uart_tx, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_tx", uart_tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (15 * DIV) @(negedge clk);
    run(0, 16'h0100, 32'h0, 4'h0, 32'hCAFEF00D, 2, 0, "read_after_rst");
    for (int i = 0; i < 8; i++)
      run(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom), $urandom,
          $urandom_range(0, WB_TO + 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
